// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   sched_state_e   : scheduler FSM encoding
//   DEF_NUM_REQ     : default number of requesters
//   DEF_WDOG_CYCLES : default owner-inactivity limit (clocks)
//   clog2_min1      : $clog2 that never returns 0, for counter/index widths
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_OWN     = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RELEASE = 2'd3
    } sched_state_e;

    localparam int DEF_NUM_REQ     = 5;
    localparam int DEF_WDOG_CYCLES = 100000;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i : request levels
//   ptr_i : index with highest priority this round
//   gnt_o : one-hot winner, the first set request at or after ptr_i (wrapping); zero when idle
module uart_tx_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int PW      = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest set request
    // is the last one written and therefore wins.
    always_comb begin
        gnt_o = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ packet senders. A requester is
// granted a whole frame; its bytes are forwarded one at a time, each only once
// the UART has gone busy and idle again after the previous byte.
//
// Optional feature: define TX_SCHED_WDOG_EN to enable the owner-inactivity
// watchdog (WDOG_CYCLES clocks); without it wdog_abort_o is tied low.
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset (release synchronised)
//   req_i           : per-requester frame-pending level
//   req_start_i     : per-requester byte strobe
//   req_data_i      : byte of requester i at [8i+7:8i]
//   req_last_i      : marks the strobed byte as last of frame
//   uart_busy_i     : UART busy level
//   grant_o         : one-hot current owner
//   tx_start_o      : one-cycle byte launch to UART
//   tx_data_o       : launched byte
//   frame_done_o    : pulse when owned frame fully transmitted
//   wdog_abort_o    : pulse when the watchdog revokes an idle owner
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   req_start_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    input  logic                 uart_busy_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 tx_start_o,
    output logic [7:0]           tx_data_o,
    output logic                 frame_done_o,
    output logic                 wdog_abort_o
);

    localparam int PW = clog2_min1(NUM_REQ);

    // Reset asserts immediately; its release is retimed to the clock.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    sched_state_e       state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               byte_free_q, byte_free_d;
    logic               busy_seen_q, busy_seen_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               frame_done_q, frame_done_d;

`ifdef TX_SCHED_WDOG_EN
    localparam int            WW        = clog2_min1(WDOG_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_abort_q, wdog_abort_d;
`endif

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]      arb_idx;

    uart_tx_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_arbiter (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) arb_idx = PW'(i);
        end
    end

    // Only the owner's lane is ever looked at, so other strobes are ignored.
    logic       own_req, own_start, own_last, fwd;
    logic [7:0] own_data;

    assign own_req   = req_i[owner_q];
    assign own_start = req_start_i[owner_q];
    assign own_last  = req_last_i[owner_q];
    assign own_data  = req_data_i[{owner_q, 3'b000} +: 8];
    assign fwd       = (state_q == ST_OWN) && own_start && byte_free_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        frame_done_d = 1'b0;
        byte_free_d  = byte_free_q;
        busy_seen_d  = busy_seen_q;
`ifdef TX_SCHED_WDOG_EN
        wdog_cnt_d   = '0;
        wdog_abort_d = 1'b0;
`endif

        // A launched byte is finished once the UART has been seen busy and then idle.
        if (!byte_free_q) begin
            if (uart_busy_i)      busy_seen_d = 1'b1;
            else if (busy_seen_q) byte_free_d = 1'b1;
        end

        case (state_q)
            ST_ARB: begin
                if (|req_i) begin
                    grant_d = arb_gnt;
                    owner_d = arb_idx;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
`ifdef TX_SCHED_WDOG_EN
                wdog_cnt_d = wdog_cnt_q + 1'b1;
`endif
                if (fwd) begin
                    tx_start_d  = 1'b1;
                    tx_data_d   = own_data;
                    byte_free_d = 1'b0;
                    busy_seen_d = 1'b0;
`ifdef TX_SCHED_WDOG_EN
                    wdog_cnt_d  = '0;
`endif
                    if (own_last || !own_req) state_d = ST_DRAIN;
                end else if (!own_req) begin
                    state_d = ST_DRAIN;
                end
`ifdef TX_SCHED_WDOG_EN
                else if (wdog_cnt_q == WDOG_LAST) begin
                    wdog_abort_d = 1'b1;
                    grant_d      = '0;
                    state_d      = ST_RELEASE;
                end
`endif
            end
            ST_DRAIN: begin
                if (byte_free_q) begin
                    frame_done_d = 1'b1;
                    grant_d      = '0;
                    state_d      = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                rr_ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
                state_d  = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= ST_ARB;
            grant_q      <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            byte_free_q  <= 1'b1;
            busy_seen_q  <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            byte_free_q  <= byte_free_d;
            busy_seen_q  <= busy_seen_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef TX_SCHED_WDOG_EN
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wdog_cnt_q   <= '0;
            wdog_abort_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_abort_q <= wdog_abort_d;
        end
    end
    assign wdog_abort_o = wdog_abort_q;
`else
    assign wdog_abort_o = 1'b0;
`endif

    assign grant_o      = grant_q;
    assign tx_start_o   = tx_start_q;
    assign tx_data_o    = tx_data_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    localparam int N    = 5;
    localparam int WDOG = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [N-1:0]     req_i = '0;
    logic [N-1:0]     req_start_i = '0;
    logic [8*N-1:0]   req_data_i = '0;
    logic [N-1:0]     req_last_i = '0;
    logic             uart_busy_i;
    logic [N-1:0]     grant_o;
    logic             tx_start_o;
    logic [7:0]       tx_data_o;
    logic             frame_done_o;
    logic             wdog_abort_o;

    uart_tx_scheduler #(
        .NUM_REQ     (N),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .req_start_i  (req_start_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .uart_busy_i  (uart_busy_i),
        .grant_o      (grant_o),
        .tx_start_o   (tx_start_o),
        .tx_data_o    (tx_data_o),
        .frame_done_o (frame_done_o),
        .wdog_abort_o (wdog_abort_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int abort_cnt   = 0;
    logic [7:0] exp_q[$];

    // UART model: busy for 10 clocks after each launch.
    int busy_cnt = 0;
    assign uart_busy_i = (busy_cnt != 0);
    always @(posedge clk_i) begin
        if (tx_start_o)       busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // Scoreboard consumer plus launch-spacing watcher.
    bit mon_free = 1'b1;
    bit mon_seen = 1'b0;
    always @(negedge clk_i) begin
        logic [7:0] e;
        if (!rst_ni) begin
            mon_free = 1'b1;
            mon_seen = 1'b0;
        end else begin
            if (frame_done_o) done_cnt++;
            if (wdog_abort_o) abort_cnt++;
            if (tx_start_o) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL tx_byte: got tx_data=%02h, required no tx_start", tx_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data_o !== e) begin
                        miscompares++;
                        $display("FAIL tx_byte: got tx_data=%02h, required %02h", tx_data_o, e);
                    end
                end
                vectors++;
                if (!mon_free) begin
                    miscompares++;
                    $display("FAIL tx_spacing: got tx_start without busy high-low, required none");
                end
                mon_free = 1'b0;
                mon_seen = 1'b0;
            end else if (!mon_free) begin
                if (uart_busy_i)   mon_seen = 1'b1;
                else if (mon_seen) mon_free = 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_i       = '0;
        req_start_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        exp_q.delete();
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic wait_idle();
        int run = 0;
        int n   = 0;
        while (run < 3 && n < 200) begin
            @(negedge clk_i);
            n++;
            if (!uart_busy_i && !tx_start_o) run++;
            else                             run = 0;
        end
        if (run < 3) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: got uart still busy after %0d clocks, required idle", n);
        end
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] exp);
        int n = 0;
        @(negedge clk_i);
        while (grant_o == '0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        vectors++;
        if (grant_o !== exp) begin
            miscompares++;
            $display("FAIL %s: got grant=%b, required %b", name, grant_o, exp);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!frame_done_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        vectors++;
        if (frame_done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got frame_done=%b after %0d clocks, required 1", name, frame_done_o, n);
        end
    endtask

    // Strobe one byte; checks tx_start exactly one clock after the sampling edge.
    task automatic strobe(input int idx, input logic [7:0] d, input logic last,
                          input logic exp_fwd, input logic drop);
        @(posedge clk_i);
        #1;
        req_start_i[idx]        = 1'b1;
        req_data_i[idx*8 +: 8]  = d;
        req_last_i[idx]         = last;
        if (exp_fwd) exp_q.push_back(d);
        @(posedge clk_i);
        #1;
        req_start_i = '0;
        req_last_i  = '0;
        if (drop) req_i[idx] = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (tx_start_o !== exp_fwd) begin
            miscompares++;
            $display("FAIL strobe_%0d_%02h: got tx_start=%b, required %b", idx, d, tx_start_o, exp_fwd);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        vectors++;
        if ({grant_o, tx_start_o, tx_data_o, frame_done_o, wdog_abort_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got grant=%b tx_start=%b tx_data=%02h done=%b abort=%b, required all 0",
                     grant_o, tx_start_o, tx_data_o, frame_done_o, wdog_abort_o);
        end
        do_reset();
        repeat (8) @(negedge clk_i);
        vectors++;
        if (grant_o !== '0) begin
            miscompares++;
            $display("FAIL idle_grant: got grant=%b, required 00000", grant_o);
        end
    endtask

    task automatic test_single_frame();
        int d0;
        do_reset();
        d0 = done_cnt;
        req_i = 5'b00001;
        wait_grant("sf_grant", 5'b00001);
        wait_idle();
        strobe(0, 8'h53, 1'b0, 1'b1, 1'b0);
        wait_idle();
        strobe(0, 8'h44, 1'b0, 1'b1, 1'b0);
        wait_idle();
        strobe(0, 8'h4B, 1'b1, 1'b1, 1'b1);
        wait_done("sf_done");
        repeat (4) @(negedge clk_i);
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL sf_done_count: got %0d, required 1", done_cnt - d0);
        end
        vectors++;
        if (grant_o !== '0) begin
            miscompares++;
            $display("FAIL sf_grant_after: got grant=%b, required 00000", grant_o);
        end
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL sf_pending: got %0d bytes not launched, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_i = 5'b10110;
        wait_grant("rr_first", 5'b00010);
        wait_idle();
        strobe(1, 8'hA1, 1'b1, 1'b1, 1'b1);
        wait_done("rr_done1");
        wait_grant("rr_second", 5'b00100);
        wait_idle();
        strobe(2, 8'hA2, 1'b1, 1'b1, 1'b1);
        wait_done("rr_done2");
        wait_grant("rr_third", 5'b10000);
        wait_idle();
        strobe(4, 8'hA4, 1'b1, 1'b1, 1'b1);
        wait_done("rr_done4");
        req_i = 5'b00011;
        wait_grant("rr_wrap", 5'b00001);
        wait_idle();
        strobe(0, 8'hA0, 1'b1, 1'b1, 1'b1);
        wait_done("rr_done0");
        wait_grant("rr_after_wrap", 5'b00010);
    endtask

    task automatic test_drop();
        do_reset();
        req_i = 5'b01000;
        wait_grant("drop_grant", 5'b01000);
        req_i[0] = 1'b1;
        wait_idle();
        strobe(3, 8'h11, 1'b0, 1'b1, 1'b0);
        strobe(3, 8'h22, 1'b0, 1'b0, 1'b0);
        wait_idle();
        strobe(0, 8'hFF, 1'b0, 1'b0, 1'b0);
        strobe(3, 8'h33, 1'b1, 1'b1, 1'b1);
        wait_done("drop_done");
        wait_grant("drop_next", 5'b00001);
    endtask

    task automatic test_reset_drain();
        int n = 0;
        do_reset();
        req_i = 5'b00001;
        wait_grant("rd_grant", 5'b00001);
        wait_idle();
        strobe(0, 8'h4B, 1'b1, 1'b1, 1'b0);
        while (!uart_busy_i && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        req_i = 5'b00101;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        vectors++;
        if ({grant_o, tx_start_o, tx_data_o, frame_done_o, wdog_abort_o} !== '0) begin
            miscompares++;
            $display("FAIL rd_async_reset: got grant=%b tx_start=%b tx_data=%02h done=%b, required all 0",
                     grant_o, tx_start_o, tx_data_o, frame_done_o);
        end
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        wait_grant("rd_regrant", 5'b00001);
    endtask

    task automatic test_wdog();
        int d0;
        int a0;
        int edges = 0;
        do_reset();
        req_i = 5'b00011;
        wait_grant("wd_grant", 5'b00001);
        wait_idle();
        d0 = done_cnt;
        a0 = abort_cnt;
        strobe(0, 8'h5A, 1'b0, 1'b1, 1'b0);
`ifdef TX_SCHED_WDOG_EN
        while (!wdog_abort_o && edges < 40) begin
            @(negedge clk_i);
            edges++;
        end
        vectors++;
        if (edges !== WDOG) begin
            miscompares++;
            $display("FAIL wd_abort_time: got abort %0d clocks after forward, required %0d", edges, WDOG);
        end
        wait_grant("wd_next", 5'b00010);
        vectors++;
        if (done_cnt !== d0) begin
            miscompares++;
            $display("FAIL wd_no_done: got %0d frame_done, required 0", done_cnt - d0);
        end
`else
        repeat (40) @(negedge clk_i);
        edges = 40;
        vectors++;
        if (grant_o !== 5'b00001) begin
            miscompares++;
            $display("FAIL wd_hold: got grant=%b after %0d idle clocks, required 00001", grant_o, edges);
        end
        vectors++;
        if (abort_cnt !== a0) begin
            miscompares++;
            $display("FAIL wd_no_abort: got %0d wdog_abort, required 0", abort_cnt - a0);
        end
        req_i[0] = 1'b0;
        wait_done("wd_drop_done");
        wait_grant("wd_next", 5'b00010);
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL wd_done_count: got %0d, required 1", done_cnt - d0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_drop();
        test_reset_drain();
        test_wdog();
        repeat (20) @(negedge clk_i);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL final_pending: got %0d bytes not launched, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
